// File: rtl/util_wdg_pkg.sv
// Shared types and constants for the watchdog supervisor: FSM state encoding, strike counter
// width and the default disarm key.
package util_wdg_pkg;

    // Encoding is visible to software through fsm_state.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad1  = 3'd1,
        StArmed  = 3'd2,
        StLoad2  = 3'd3,
        StWarn   = 3'd4,
        StReset  = 3'd5,
        StLocked = 3'd6
    } wdg_state_e;

    localparam int unsigned          STRIKE_W           = 4;
    localparam logic [STRIKE_W-1:0]  STRIKE_SAT         = 4'hF;
    localparam logic [31:0]          DISARM_KEY_DEFAULT = 32'h5A5AA5A5;

    function automatic logic [STRIKE_W-1:0] strike_inc(input logic [STRIKE_W-1:0] cnt);
        return (cnt == STRIKE_SAT) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/util_wdg_supervisor_if.sv
// CPU-side control bus of the watchdog supervisor: config handshake plus arm/kick/disarm strobes.
interface util_wdg_supervisor_if #(
    parameter int unsigned PRESET_W = 32
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [PRESET_W-1:0] cfg_preset;
    logic [PRESET_W-1:0] cfg_preset2;
    logic                arm;
    logic                kick;
    logic                disarm_req;
    logic [31:0]         disarm_key;

    modport master (
        output cfg_valid, cfg_preset, cfg_preset2, arm, kick, disarm_req, disarm_key,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_preset, cfg_preset2, arm, kick, disarm_req, disarm_key,
        output cfg_ready
    );
endinterface

// File: rtl/util_wdg_pulse_cnt.sv
// Loadable down-counter producing a LEN-cycle registered pulse; start restarts the pulse,
// clr cancels it.
module util_wdg_pulse_cnt #(
    parameter int unsigned LEN = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic clr,
    output logic active,
    output logic last
);
    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (clr) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (start) begin
            cnt_d    = CNT_W'(LEN - 1);
            active_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign last   = active_q && (cnt_q == '0);

endmodule

// File: rtl/util_wdg_supervisor.sv
// Sequencing controller for one watchdog: config, arm/disarm, kick service and timeout
// escalation (warning IRQ, system reset request, lockout).
module util_wdg_supervisor
    import util_wdg_pkg::*;
#(
    parameter int unsigned PRESET_W    = 32,
    parameter int unsigned LOAD_CYC    = 2,
    parameter int unsigned RST_PULSE   = 16,
    parameter int unsigned MAX_STRIKES = 3,
    parameter logic [31:0] DISARM_KEY  = DISARM_KEY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    util_wdg_supervisor_if.slave  cfg,
    output logic                  wd_en,
    output logic                  wd_load,
    output logic [PRESET_W-1:0]   wd_preset,
    input  logic                  wd_inactive,
    output logic                  irq_warn,
    output logic                  sys_rst_req,
    output logic [STRIKE_W-1:0]   strike_cnt,
    output logic [2:0]            fsm_state
);
    wdg_state_e          state_q, state_d;
    logic [PRESET_W-1:0] preset1_q, preset1_d, preset2_q, preset2_d;
    logic [PRESET_W-1:0] wd_preset_q, wd_preset_d, preset1_eff;
    logic [STRIKE_W-1:0] strike_q, strike_d;
    logic                wd_en_q, irq_warn_q, sys_rst_req_q, cfg_ready_q;
    logic                inact_q, load_blank_q;
    logic                load_start, load_clr, rst_start;
    logic                load_active, load_last, rst_active, rst_last;
    logic                cfg_fire, key_ok, timeout;

    util_wdg_pulse_cnt #(.LEN(LOAD_CYC)) u_load_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .start  (load_start),
        .clr    (load_clr),
        .active (load_active),
        .last   (load_last)
    );

    util_wdg_pulse_cnt #(.LEN(RST_PULSE)) u_rst_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .start  (rst_start),
        .clr    (1'b0),
        .active (rst_active),
        .last   (rst_last)
    );

    assign cfg_fire    = cfg.cfg_valid && cfg_ready_q;
    assign preset1_eff = cfg_fire ? cfg.cfg_preset : preset1_q;
    assign key_ok      = (cfg.disarm_key == DISARM_KEY);
    // The watchdog flag may still reflect the old count during a reload and the cycle after it.
    assign timeout     = wd_inactive && !inact_q && !load_active && !load_blank_q;

    always_comb begin
        state_d     = state_q;
        preset1_d   = preset1_q;
        preset2_d   = preset2_q;
        wd_preset_d = wd_preset_q;
        strike_d    = strike_q;
        load_start  = 1'b0;
        load_clr    = 1'b0;
        rst_start   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    preset1_d = cfg.cfg_preset;
                    preset2_d = cfg.cfg_preset2;
                    strike_d  = '0;
                end
                if (cfg.arm && (preset1_eff != '0)) begin
                    state_d     = StLoad1;
                    load_start  = 1'b1;
                    wd_preset_d = preset1_eff;
                end
            end
            StLoad1: if (load_last) state_d = StArmed;
            StArmed: begin
                if (cfg.disarm_req) begin
                    if (key_ok) begin
                        state_d  = StIdle;
                        load_clr = 1'b1;
                    end else begin
                        state_d     = StLoad2;
                        load_start  = 1'b1;
                        wd_preset_d = preset2_q;
                    end
                end else if (cfg.kick) begin
                    load_start = 1'b1;
                end else if (timeout) begin
                    state_d     = StLoad2;
                    load_start  = 1'b1;
                    wd_preset_d = preset2_q;
                end
            end
            StLoad2: if (load_last) state_d = StWarn;
            StWarn: begin
                if (cfg.disarm_req && key_ok) begin
                    state_d  = StIdle;
                    load_clr = 1'b1;
                end else if (!cfg.disarm_req && cfg.kick) begin
                    state_d     = StLoad1;
                    load_start  = 1'b1;
                    wd_preset_d = preset1_q;
                end else if (cfg.disarm_req || timeout) begin
                    state_d   = StReset;
                    rst_start = 1'b1;
                    load_clr  = 1'b1;
                    strike_d  = strike_inc(strike_q);
                end
            end
            StReset: begin
                // An idle pulse counter here can only mean a lost start; leave rather than hang.
                if (rst_last || !rst_active) begin
                    if (strike_q == STRIKE_W'(MAX_STRIKES)) begin
                        state_d = StLocked;
                    end else begin
                        state_d     = StLoad1;
                        load_start  = 1'b1;
                        wd_preset_d = preset1_q;
                    end
                end
            end
            StLocked: state_d = StLocked;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            preset1_q     <= '0;
            preset2_q     <= '0;
            wd_preset_q   <= '0;
            strike_q      <= '0;
            wd_en_q       <= 1'b0;
            irq_warn_q    <= 1'b0;
            sys_rst_req_q <= 1'b0;
            cfg_ready_q   <= 1'b1;
            inact_q       <= 1'b0;
            load_blank_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            preset1_q     <= preset1_d;
            preset2_q     <= preset2_d;
            wd_preset_q   <= wd_preset_d;
            strike_q      <= strike_d;
            wd_en_q       <= state_d inside {StLoad1, StArmed, StLoad2, StWarn};
            irq_warn_q    <= state_d inside {StLoad2, StWarn};
            sys_rst_req_q <= state_d inside {StReset, StLocked};
            cfg_ready_q   <= (state_d == StIdle);
            inact_q       <= wd_inactive;
            load_blank_q  <= load_active;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign wd_en         = wd_en_q;
    assign wd_load       = load_active;
    assign wd_preset     = wd_preset_q;
    assign irq_warn      = irq_warn_q;
    assign sys_rst_req   = sys_rst_req_q;
    assign strike_cnt    = strike_q;
    assign fsm_state     = state_q;

endmodule
